// File: rtl/pc_injector_x_pkg.sv
// Shared types for the pc_injector_x row-head stage.
// Entry layout is {parity, pc}; the arbiter select is an enum.
package pc_injector_x_pkg;

    localparam int PC_WIDTH_DEF = 8;

    typedef struct packed {
        logic                    parity;
        logic [PC_WIDTH_DEF-1:0] pc;
    } pc_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RET,
        SEL_INJ
    } sel_e;

    function automatic pc_entry_t mk_entry(
        input logic                    parity,
        input logic [PC_WIDTH_DEF-1:0] pc
    );
        pc_entry_t e;
        e.parity = parity;
        e.pc     = pc;
        return e;
    endfunction

endpackage

// File: rtl/pc_injector_x_if.sv
// Valid/ready channels around the row-head stage: new-thread start,
// wrap-around return and the registered output toward the row.
interface pc_injector_x_if #(
    parameter int PC_WIDTH = 8
);
    logic              start_valid;
    logic [PC_WIDTH:0] start_data;
    logic              start_ready;
    logic              ret_valid;
    logic [PC_WIDTH:0] ret_data;
    logic              ret_ready;
    logic              out_valid;
    logic [PC_WIDTH:0] out_data;
    logic              out_ready;

    modport master (
        output start_valid, start_data,
        input  start_ready,
        output ret_valid, ret_data,
        input  ret_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  start_valid, start_data,
        output start_ready,
        input  ret_valid, ret_data,
        output ret_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/pc_injector_x_pc_slot.sv
// Single-entry holding register; accepts only when empty, so an entry
// dequeued in one cycle makes room for a new one in the next.
module pc_slot #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         deq_i
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && !valid_q) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (deq_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready_o  = !valid_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
endmodule

// File: rtl/pc_injector_x.sv
// Row-head stage: merges injected thread PCs with wrap-around traffic
// into one registered channel, with starvation guard and idle detect.
module pc_injector_x
    import pc_injector_x_pkg::*;
#(
    parameter int PC_WIDTH     = PC_WIDTH_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int IDLE_CYCLES  = 3,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    pc_injector_x_if.slave         bus,
    output logic                   idle,
    output logic [COUNT_WIDTH-1:0] injected_cnt
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYCLES);

    logic              inj_valid;
    logic [PC_WIDTH:0] inj_data;
    logic              load_en;
    logic              pick_inj;
    logic              quiet;
    sel_e              sel;

    logic                   out_valid_q, out_valid_d;
    logic [PC_WIDTH:0]      out_data_q, out_data_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
    logic                   idle_q, idle_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    pc_slot #(.W(PC_WIDTH + 1)) u_inj_slot (
        .clk        (clk),
        .rst_n      (rst),
        .in_valid_i (bus.start_valid),
        .in_data_i  (bus.start_data),
        .in_ready_o (bus.start_ready),
        .out_valid_o(inj_valid),
        .out_data_o (inj_data),
        .deq_i      (pick_inj)
    );

    assign load_en  = !out_valid_q || bus.out_ready;
    assign pick_inj = (sel == SEL_INJ);
    assign quiet    = !bus.ret_valid && !inj_valid &&
                      !bus.start_valid && !out_valid_q;

    // A starved inject beats return traffic; otherwise return wins.
    always_comb begin
        sel = SEL_NONE;
        if (load_en) begin
            if (inj_valid && enable && starve_q == STARVE_MAX)
                sel = SEL_INJ;
            else if (bus.ret_valid)
                sel = SEL_RET;
            else if (inj_valid && enable)
                sel = SEL_INJ;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        starve_d    = starve_q;
        idle_cnt_d  = idle_cnt_q;
        cnt_d       = cnt_q;
        if (load_en) begin
            out_valid_d = (sel != SEL_NONE);
            if (sel == SEL_INJ)
                out_data_d = inj_data;
            else if (sel == SEL_RET)
                out_data_d = bus.ret_data;
        end
        if (pick_inj || !inj_valid || !enable)
            starve_d = '0;
        else if (starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);
        if (pick_inj)
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        if (!quiet)
            idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX)
            idle_cnt_d = idle_cnt_q + IW'(1);
        idle_d = (idle_cnt_d == IDLE_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            starve_q    <= '0;
            idle_cnt_q  <= '0;
            idle_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            starve_q    <= starve_d;
            idle_cnt_q  <= idle_cnt_d;
            idle_q      <= idle_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ret_ready = load_en && !pick_inj;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign idle          = idle_q;
    assign injected_cnt  = cnt_q;
endmodule
